rr_mux_arbiter_8: RTL and testbench
===================================

# rr_mux_arbiter_8

Round-robin arbiter and sequencer for an 8:1 single-bit multiplexer datapath. Eight requesters share one serial output bit. The block grants one requester at a time, drives the mux select from the grant, and registers the selected data bit with a valid flag. It sits between the requesting sources and the downstream single-bit sink, and it is the only block that drives the mux select.

## Interface
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held; legal range 1..15.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk.
- req  input  8  per-requester request; req[k] high = requester k wants the output.
- din  input  8  per-requester data bit; din[k] is meaningful only while k is granted.
- gnt  output  8  one-hot grant (or all zero when idle); registered.
- sel  output  3  binary index of the current or last grant; registered; drives the mux select.
- dout  output  1  registered mux output, equal to din[sel] sampled one cycle earlier.
- dout_valid  output  1  dout carries data from a granted, still-requesting source.
- busy  output  1  high whenever gnt is non-zero.

## Operation
- Internal state:
  - FSM {IDLE, GRANT}.
  - ptr[2:0]: search start position.
  - hold_cnt[3:0].
- Winner search: the first k with req[k]=1, scanning ptr, ptr+1, …, ptr+7 mod 8.
- IDLE:
  - If req is non-zero at a rising edge, go to GRANT.
  - On that edge: gnt = one-hot(winner), sel = winner, hold_cnt = 1, ptr = winner+1 mod 8.
  - If req is zero, stay in IDLE; gnt = 0; sel keeps its value.
- GRANT, release condition: req[sel]=0, or hold_cnt == MAX_HOLD.
- GRANT, no release: gnt and sel hold; hold_cnt increments.
- GRANT, release with any other req bit set:
  - Re-arbitrate on the same edge with no idle cycle.
  - The search starts at ptr (already sel+1).
  - The current holder can win again only if its req is high and no other requester's req is high. In that case hold_cnt restarts at 1.
- GRANT, release with no other request (and the holder's req low or the holder excluded): go to IDLE; gnt = 0.
- Datapath: every edge, dout <= din[sel] and dout_valid <= (state==GRANT) & req[sel].
- In IDLE, dout_valid = 0; dout keeps sampling din[sel] (don't-care).
- Invariants:
  - gnt is always zero or one-hot.
  - When gnt is non-zero, gnt == one-hot(sel).
  - busy == |gnt.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - gnt=0, sel=0, dout=0, dout_valid=0, busy=0.
  - FSM=IDLE, ptr=0, hold_cnt=0.
- Reset during GRANT aborts the grant with no completion cycle. After release, the first search starts at index 0.
- Grant latency: req rising before edge N gives gnt valid after edge N (1 cycle).
- Data latency: din[sel] sampled at edge M appears on dout/dout_valid after edge M.
- The first valid dout of a grant appears one cycle after gnt asserts.
- Maximum grant length: MAX_HOLD cycles; the grant changes or drops at the edge where hold_cnt == MAX_HOLD.
- A requester that drops req is released at the next edge. Its final cycle shows dout_valid=0.
- Back-to-back grants between different requesters have zero idle cycles; gnt switches one-hot in a single edge.
- Wrap-around: ptr is mod 8; after a grant to 7, the search starts at 0.
- Starvation bound: any held req is granted within 7×MAX_HOLD+1 cycles.
- MAX_HOLD=1: a new grant is made every cycle whenever multiple requesters are active.

## Test plan
- Reset mid-grant:
  - Stimulus: req=8'h08, wait until gnt=8'h08, pull rst_n low between edges.
  - Required: gnt, sel, dout, dout_valid, and busy all go to 0 immediately.
  - Then: after release with req=8'h81, first gnt=8'h01.
- Single holder, MAX_HOLD=4:
  - Stimulus: req=8'h20 for 10 cycles, din[5] toggling.
  - Required: gnt=8'h20 and sel=5 continuously; hold_cnt cycles 1..4 and restarts with no gap; dout equals din[5] delayed one cycle; dout_valid=1 from the cycle after grant.
- All requesting:
  - Stimulus: req=8'hFF constant from reset.
  - Required: grants in order 0,1,…,7,0, each exactly 4 cycles; busy stays 1; no idle cycle.
- Pointer fairness:
  - Stimulus: grant 3 completes, then req=8'h44.
  - Required: gnt=8'h40 first, then 8'h04.
- Early drop:
  - Stimulus: req[1] high for 2 cycles of grant, then low, with req[4] high.
  - Required: gnt moves 8'h02→8'h10 at the edge after the drop; dout_valid=0 for the drop cycle.
- Wrap:
  - Stimulus: sel=7 releases by MAX_HOLD while req=8'h81.
  - Required: the next gnt is 8'h01, not 8'h80.

Source files
------------

// File: rtl/rr_mux_arbiter_8_if.sv
// Handshake bundle between the eight requesters/mux datapath and the round-robin arbiter.
// The master modport is the arbiter side; the slave modport is the requester/sink side.
interface rr_mux_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       dout;
  logic       dout_valid;
  logic       busy;

  modport master (
    input  req,
    input  din,
    output gnt,
    output sel,
    output dout,
    output dout_valid,
    output busy
  );

  modport slave (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  dout,
    input  dout_valid,
    input  busy
  );
endinterface

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter for an 8:1 single-bit mux: grants one requester at a time,
// limits each grant to MAX_HOLD cycles and registers the selected data bit with a valid flag.
module rr_mux_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_mux_arbiter_8_if.master     bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       dout_q;
  logic       dout_valid_q;
  logic       busy_q;

  logic [7:0] others_s;
  logic [3:0] win_s;
  logic [3:0] win_oth_s;
  logic       release_s;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [3:0] find_winner(input logic [7:0] req_v, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (req_v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'(8'h01 << idx);
  endfunction

  // Next-state logic: winner search, hold counting and grant hand-over.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    others_s  = bus.req & ~onehot(sel_q);
    win_s     = find_winner(bus.req, ptr_q);
    win_oth_s = find_winner(others_s, ptr_q);
    release_s = ~bus.req[sel_q] | (hold_q == MAX_HOLD_C);

    case (state_q)
      IDLE: begin
        if (win_s[3]) begin
          state_d = GRANT;
          gnt_d   = onehot(win_s[2:0]);
          sel_d   = win_s[2:0];
          hold_d  = 4'd1;
          ptr_d   = win_s[2:0] + 3'd1;
        end else begin
          gnt_d   = 8'h00;
        end
      end
      GRANT: begin
        if (!release_s) begin
          hold_d = hold_q + 4'd1;
        end else if (win_oth_s[3]) begin
          gnt_d  = onehot(win_oth_s[2:0]);
          sel_d  = win_oth_s[2:0];
          hold_d = 4'd1;
          ptr_d  = win_oth_s[2:0] + 3'd1;
        end else if (bus.req[sel_q]) begin
          // Sole requester hit the hold limit: re-grant it; ptr already points past it.
          hold_d = 4'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          hold_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
        hold_d  = 4'd0;
      end
    endcase
  end

  // Arbiter state and registered grant/select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= |gnt_d;
    end
  end

  // Registered mux output; valid only while the selected source is granted and still requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= bus.din[sel_q];
      dout_valid_q <= (state_q == GRANT) & bus.req[sel_q];
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed bench for rr_mux_arbiter_8 (MAX_HOLD=4): reset, rotation, hold limit,
// pointer fairness, early drop and wrap-around, each with hand-computed expectations.
module tb_rr_mux_arbiter_8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  rr_mux_arbiter_8_if bus ();

  rr_mux_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] oh(input int k);
    logic [2:0] idx;
    idx = k[2:0];
    return 8'(8'h01 << idx);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; leaves reset released before the next edge.
  task automatic apply_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    bus.din = 8'h00;
    #3;
    rst_n   = 1'b1;
  endtask

  initial begin
    logic       seen;
    logic [9:0] pat;
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b1;
    bus.req = 8'h00;
    bus.din = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt",   bus.gnt,               8'h00);
    chk("rst_sel",   {5'b0, bus.sel},       8'h00);
    chk("rst_dout",  {7'b0, bus.dout},      8'h00);
    chk("rst_dv",    {7'b0, bus.dout_valid}, 8'h00);
    chk("rst_busy",  {7'b0, bus.busy},      8'h00);

    // All requesting from reset: 0..7 then 0, four cycles each, never idle
    #6;
    bus.req = 8'hFF;
    rst_n   = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("rr_gnt_k%0d_c%0d", k, c), bus.gnt, oh(k));
        chk($sformatf("rr_busy_k%0d_c%0d", k, c), {7'b0, bus.busy}, 8'h01);
        if (c == 0) begin
          chk($sformatf("rr_sel_k%0d", k), {5'b0, bus.sel}, 8'(k % 8));
        end
      end
    end

    // Reset mid-grant
    bus.req = 8'h08;
    bus.din = 8'hFF;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!seen) begin
        step();
        seen = (bus.gnt == 8'h08);
      end
    end
    chk("mid_wait_gnt3", {7'b0, seen}, 8'h01);
    step();
    chk("mid_pre_dv",   {7'b0, bus.dout_valid}, 8'h01);
    chk("mid_pre_dout", {7'b0, bus.dout},       8'h01);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_gnt",  bus.gnt,                8'h00);
    chk("mid_sel",  {5'b0, bus.sel},        8'h00);
    chk("mid_dout", {7'b0, bus.dout},       8'h00);
    chk("mid_dv",   {7'b0, bus.dout_valid}, 8'h00);
    chk("mid_busy", {7'b0, bus.busy},       8'h00);
    bus.req = 8'h81;
    #1 rst_n = 1'b1;
    step();
    chk("mid_after_gnt", bus.gnt,         8'h01);
    chk("mid_after_sel", {5'b0, bus.sel}, 8'h00);

    // Single holder: requester 5 keeps the grant across hold-limit restarts
    step();
    apply_reset();
    pat = 10'b1101001011;
    bus.req = 8'h20;
    for (int i = 0; i < 10; i++) begin
      bus.din = pat[i] ? 8'h20 : 8'hDF;
      step();
      chk($sformatf("one_gnt_%0d", i), bus.gnt, 8'h20);
      chk($sformatf("one_sel_%0d", i), {5'b0, bus.sel}, 8'h05);
      if (i == 0) begin
        chk("one_dv_first", {7'b0, bus.dout_valid}, 8'h00);
      end else begin
        chk($sformatf("one_dv_%0d", i),   {7'b0, bus.dout_valid}, 8'h01);
        chk($sformatf("one_dout_%0d", i), {7'b0, bus.dout},       {7'b0, pat[i]});
      end
    end

    // Pointer fairness: after grant 3, req=0x44 goes to 6 before 2
    apply_reset();
    bus.req = 8'h08;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("fair_g3_%0d", c), bus.gnt, 8'h08);
    end
    bus.req = 8'h44;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("fair_g6_%0d", c), bus.gnt, 8'h40);
    end
    step();
    chk("fair_g2", bus.gnt, 8'h04);
    chk("fair_sel2", {5'b0, bus.sel}, 8'h02);

    // Early drop: requester 1 drops after two cycles, requester 4 takes over
    apply_reset();
    bus.req = 8'h12;
    bus.din = 8'h02;
    step();
    chk("drop_g1_a", bus.gnt, 8'h02);
    step();
    chk("drop_g1_b", bus.gnt, 8'h02);
    chk("drop_dv_b", {7'b0, bus.dout_valid}, 8'h01);
    chk("drop_dout_b", {7'b0, bus.dout}, 8'h01);
    bus.req = 8'h10;
    bus.din = 8'h10;
    step();
    chk("drop_g4", bus.gnt, 8'h10);
    chk("drop_dv_drop", {7'b0, bus.dout_valid}, 8'h00);
    step();
    chk("drop_dv_g4", {7'b0, bus.dout_valid}, 8'h01);
    chk("drop_dout_g4", {7'b0, bus.dout}, 8'h01);
    bus.req = 8'h00;
    step();
    chk("drop_idle_gnt",  bus.gnt,          8'h00);
    chk("drop_idle_busy", {7'b0, bus.busy}, 8'h00);

    // Wrap: sel=7 releases by hold limit with req=0x81, next grant is 0
    apply_reset();
    bus.req = 8'h80;
    step();
    chk("wrap_g7_0", bus.gnt, 8'h80);
    bus.req = 8'h81;
    for (int c = 1; c < 4; c++) begin
      step();
      chk($sformatf("wrap_g7_%0d", c), bus.gnt, 8'h80);
    end
    step();
    chk("wrap_g0", bus.gnt, 8'h01);
    chk("wrap_sel0", {5'b0, bus.sel}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
